// File: rtl/avb_rr_arbiter.sv
// avb_rr_arbiter: two-master round-robin arbiter sharing one Avalon-MM slave, with read timeout
module avb_rr_arbiter #(
   parameter int          TIMEOUT      = 16,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid,
   output logic [7:0]  timeout_count
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CMD    = 2'd1;
   localparam logic [1:0] RDWAIT = 2'd2;
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic        grant;
   logic        last_grant;
   logic [7:0]  timer;
   logic        m0_req;
   logic        m1_req;
   logic        g_read;
   logic        g_write;
   logic        in_cmd;
   logic        accept;
   logic [31:0] g_address;
   logic [31:0] g_writedata;
   logic [3:0]  g_byteenable;
   logic [31:0] rsp_data;

   // forward the granted master's live command while in CMD, otherwise present an idle slave command
   always_comb begin
      m0_req         = m0_read | m0_write;
      m1_req         = m1_read | m1_write;
      g_read         = grant ? m1_read : m0_read;
      g_write        = grant ? m1_write : m0_write;
      g_address      = grant ? m1_address : m0_address;
      g_writedata    = grant ? m1_writedata : m0_writedata;
      g_byteenable   = grant ? m1_byteenable : m0_byteenable;
      in_cmd         = (state == CMD) && (g_read || g_write);
      accept         = in_cmd && !s_waitrequest;
      s_write        = in_cmd && g_write;
      s_read         = in_cmd && !g_write;
      s_address      = in_cmd ? g_address : '0;
      s_writedata    = in_cmd ? g_writedata : '0;
      s_byteenable   = in_cmd ? g_byteenable : '0;
      m0_waitrequest = !(accept && !grant);
      m1_waitrequest = !(accept && grant);
      rsp_data       = s_readdatavalid ? s_readdata : TIMEOUT_DATA;
   end

   // arbitration, transfer sequencing and read-response routing; slave data beats a same-cycle timeout
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         grant            <= 1'b0;
         last_grant       <= 1'b1;
         timer            <= '0;
         timeout_count    <= '0;
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
      end else begin
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         case (state)
            IDLE: if (m0_req || m1_req) begin
               grant <= (m0_req && m1_req) ? !last_grant : m1_req;
               state <= CMD;
            end
            CMD: if (!(g_read || g_write)) state <= IDLE;
            else if (!s_waitrequest) begin
               last_grant <= grant;
               state      <= g_write ? IDLE : RDWAIT;
               timer      <= '0;
            end
            RDWAIT: if (s_readdatavalid || timer == TIMER_LAST) begin
               if (grant) m1_readdata <= rsp_data;
               else m0_readdata <= rsp_data;
               m0_readdatavalid <= !grant;
               m1_readdatavalid <= grant;
               if (!s_readdatavalid && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
               state <= IDLE;
            end else timer <= timer + 8'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
